// File: rtl/jtkcpu_mdu_pkg.sv
// Shared mode codes, sequencer states and small helpers for the multi-cycle arithmetic unit.
`default_nettype none

package jtkcpu_mdu_pkg;

  typedef enum logic [2:0] {
    MD_MUL = 3'd0,
    MD_DIV = 3'd1,
    MD_ASL = 3'd2,
    MD_LSR = 3'd3,
    MD_ASR = 3'd4,
    MD_ROL = 3'd5,
    MD_ROR = 3'd6,
    MD_RSV = 3'd7
  } mdu_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic is_shift(input mdu_mode_e m);
    return (m == MD_ASL) || (m == MD_LSR) || (m == MD_ASR) || (m == MD_ROL) || (m == MD_ROR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/jtkcpu_mdu_abs.sv
// Conditional two's-complement negate: y = neg ? -x : x.
`default_nettype none

module jtkcpu_mdu_abs #(
  parameter int W = 16
) (
  input  logic [W-1:0] x_i,
  input  logic         neg_i,
  output logic [W-1:0] y_o
);

  assign y_o = neg_i ? (~x_i + W'(1)) : x_i;

endmodule

`default_nettype wire

// File: rtl/jtkcpu_mdu.sv
// Iterative multiply / restoring divide / shift-by-count unit with IDLE-RUN-FIX sequencing.
`default_nettype none

module jtkcpu_mdu
  import jtkcpu_mdu_pkg::*;
#(
  parameter int W    = 16,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cen,
  input  logic            start,
  input  logic [2:0]      mode,
  input  logic            sign,
  input  logic [W-1:0]    opa,
  input  logic [W-1:0]    opb,
  input  logic [CNTW-1:0] cnt,
  input  logic            cin,
  output logic            busy,
  output logic            done,
  output logic [W-1:0]    rslt,
  output logic [W-1:0]    rslt_hi,
  output logic            c,
  output logic            v,
  output logic            z,
  output logic            n
);

  localparam int CW = max_int($clog2(W) + 1, CNTW);

  mdu_state_e     st_q, st_d;
  mdu_mode_e      mode_q, mode_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   opb_q, opb_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           qneg_q, qneg_d, rneg_q, rneg_d, ovf_q, ovf_d;
  logic           done_q, done_d;
  logic [W-1:0]   rslt_q, rslt_d, rhi_q, rhi_d;
  logic           c_q, c_d, v_q, v_d, z_q, z_d, n_q, n_d;

  mdu_mode_e      mode_in;
  logic           mul_in, div_in, dz_in, arith_in, aneg_in, bneg_in, ovf_in;
  logic [W-1:0]   amag, bmag;
  logic [CW-1:0]  iter_in;

  always_comb begin
    mode_in  = mdu_mode_e'(mode);
    mul_in   = (mode_in == MD_MUL);
    div_in   = (mode_in == MD_DIV);
    dz_in    = div_in && (opb == '0);
    arith_in = mul_in || (div_in && !dz_in);
    aneg_in  = arith_in & sign & opa[W-1];
    bneg_in  = arith_in & sign & opb[W-1];
    ovf_in   = div_in & sign & (opa == {1'b1, {(W-1){1'b0}}}) & (opb == '1);
    if (arith_in)               iter_in = CW'(W);
    else if (is_shift(mode_in)) iter_in = CW'(cnt);
    else                        iter_in = '0;
  end

  jtkcpu_mdu_abs #(.W(W)) u_abs_a (.x_i(opa), .neg_i(aneg_in), .y_o(amag));
  jtkcpu_mdu_abs #(.W(W)) u_abs_b (.x_i(opb), .neg_i(bneg_in), .y_o(bmag));

  // Shift modes reuse acc[W] as the running carry and acc[W+1] as the sticky ASL overflow.
  logic [W:0]     mul_sum;
  logic           div_ge;
  logic [W-1:0]   div_rem;
  logic [W-1:0]   sh_x;
  logic           sh_c, sh_v;
  logic [2*W-1:0] acc_step;

  always_comb begin
    mul_sum = {1'b0, acc_q[2*W-1:W]} + {1'b0, opb_q & {W{acc_q[0]}}};
    div_ge  = (acc_q[2*W-1:W-1] >= {1'b0, opb_q});
    div_rem = acc_q[2*W-2:W-1] - opb_q;
    sh_x    = acc_q[W-1:0];
    sh_c    = acc_q[W];
    sh_v    = acc_q[W+1];
    case (mode_q)
      MD_ASL: begin
        sh_x = {acc_q[W-2:0], 1'b0};
        sh_c = acc_q[W-1];
        sh_v = acc_q[W+1] | (acc_q[W-1] ^ acc_q[W-2]);
      end
      MD_LSR: begin
        sh_x = {1'b0, acc_q[W-1:1]};
        sh_c = acc_q[0];
      end
      MD_ASR: begin
        sh_x = {acc_q[W-1], acc_q[W-1:1]};
        sh_c = acc_q[0];
      end
      MD_ROL: begin
        sh_x = {acc_q[W-2:0], acc_q[W]};
        sh_c = acc_q[W-1];
      end
      MD_ROR: begin
        sh_x = {acc_q[W], acc_q[W-1:1]};
        sh_c = acc_q[0];
      end
      default: ;
    endcase
    case (mode_q)
      MD_MUL:  acc_step = {mul_sum, acc_q[W-1:1]};
      MD_DIV:  acc_step = div_ge ? {div_rem, acc_q[W-2:0], 1'b1} : {acc_q[2*W-2:0], 1'b0};
      default: acc_step = {{(W-2){1'b0}}, sh_v, sh_c, sh_x};
    endcase
  end

  // Low word: product low / quotient. High word: product high / remainder.
  logic [W-1:0] fix_lo, fix_hi;
  logic         hi_neg;

  assign hi_neg = (mode_q == MD_DIV) ? rneg_q : qneg_q;

  jtkcpu_mdu_abs #(.W(W)) u_fix_lo (.x_i(acc_q[W-1:0]),   .neg_i(qneg_q), .y_o(fix_lo));
  jtkcpu_mdu_abs #(.W(W)) u_fix_hi (.x_i(acc_q[2*W-1:W]), .neg_i(hi_neg), .y_o(fix_hi));

  always_comb begin
    st_d   = st_q;
    mode_d = mode_q;
    acc_d  = acc_q;
    opb_d  = opb_q;
    cnt_d  = cnt_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    ovf_d  = ovf_q;
    done_d = 1'b0;
    rslt_d = rslt_q;
    rhi_d  = rhi_q;
    c_d    = c_q;
    v_d    = v_q;
    z_d    = z_q;
    n_d    = n_q;
    case (st_q)
      ST_IDLE: begin
        if (start) begin
          mode_d = mode_in;
          acc_d  = {{(W-1){1'b0}}, cin & ~mul_in & ~div_in, amag};
          opb_d  = bmag;
          cnt_d  = iter_in;
          qneg_d = aneg_in ^ bneg_in;
          rneg_d = aneg_in;
          ovf_d  = ovf_in;
          st_d   = (iter_in == '0) ? ST_FIX : ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d = acc_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) st_d = ST_FIX;
      end
      ST_FIX: begin
        done_d = 1'b1;
        st_d   = ST_IDLE;
        rslt_d = acc_q[W-1:0];
        rhi_d  = '0;
        c_d    = 1'b0;
        v_d    = 1'b0;
        case (mode_q)
          MD_MUL: begin
            // Negating a 2W value: high word is -hi only when the low word is zero, ~hi otherwise.
            rslt_d = fix_lo;
            rhi_d  = (qneg_q && (acc_q[W-1:0] != '0)) ? ~acc_q[2*W-1:W] : fix_hi;
            c_d    = fix_lo[W-1];
          end
          MD_DIV: begin
            if (opb_q == '0) begin
              rslt_d = '1;
              rhi_d  = acc_q[W-1:0];
              c_d    = 1'b1;
              v_d    = 1'b1;
            end else begin
              rslt_d = fix_lo;
              rhi_d  = fix_hi;
              v_d    = ovf_q;
            end
          end
          MD_RSV: c_d = acc_q[W];
          default: begin
            c_d = acc_q[W];
            v_d = acc_q[W+1];
          end
        endcase
        z_d = (rslt_d == '0) && ((mode_q != MD_MUL) || (rhi_d == '0));
        n_d = (mode_q == MD_MUL) ? rhi_d[W-1] : rslt_d[W-1];
        if (mode_q == MD_RSV) begin
          z_d = 1'b0;
          n_d = 1'b0;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= ST_IDLE;
      mode_q <= MD_MUL;
      acc_q  <= '0;
      opb_q  <= '0;
      cnt_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
      rslt_q <= '0;
      rhi_q  <= '0;
      c_q    <= 1'b0;
      v_q    <= 1'b0;
      z_q    <= 1'b0;
      n_q    <= 1'b0;
    end else if (cen) begin
      st_q   <= st_d;
      mode_q <= mode_d;
      acc_q  <= acc_d;
      opb_q  <= opb_d;
      cnt_q  <= cnt_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      ovf_q  <= ovf_d;
      done_q <= done_d;
      rslt_q <= rslt_d;
      rhi_q  <= rhi_d;
      c_q    <= c_d;
      v_q    <= v_d;
      z_q    <= z_d;
      n_q    <= n_d;
    end
  end

  assign busy    = (st_q != ST_IDLE);
  assign done    = done_q;
  assign rslt    = rslt_q;
  assign rslt_hi = rhi_q;
  assign c       = c_q;
  assign v       = v_q;
  assign z       = z_q;
  assign n       = n_q;

endmodule

`default_nettype wire

// File: tb/tb_jtkcpu_mdu.sv
// Scoreboard bench for jtkcpu_mdu (W=16): directed cases, random traffic with cen gaps, handshake and reset abort.
`default_nettype none

module tb_jtkcpu_mdu;

  localparam int W    = 16;
  localparam int CNTW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cen = 1'b1;
  logic            start = 1'b0;
  logic [2:0]      mode = '0;
  logic            sign = 1'b0;
  logic [W-1:0]    opa = '0;
  logic [W-1:0]    opb = '0;
  logic [CNTW-1:0] cnt = '0;
  logic            cin = 1'b0;
  logic            busy, done, c, v, z, n;
  logic [W-1:0]    rslt, rslt_hi;

  jtkcpu_mdu #(.W(W), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .start(start), .mode(mode), .sign(sign),
    .opa(opa), .opb(opb), .cnt(cnt), .cin(cin), .busy(busy), .done(done),
    .rslt(rslt), .rslt_hi(rslt_hi), .c(c), .v(v), .z(z), .n(n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] r;
    logic [W-1:0] rh;
    logic         c, v, z, n;
    int           lat;
    int           e0;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ecnt = 0;
  bit   cen_rand = 1'b0;

  always @(posedge clk) if (cen && rst_n) ecnt <= ecnt + 1;

  initial forever begin
    @(negedge clk);
    cen = cen_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Reference: plain integer arithmetic, rotates as (W+1)-bit rotations through carry.
  function automatic exp_t model(input logic [2:0] m, input logic s, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [CNTW-1:0] k, input logic ci);
    exp_t e;
    longint sa, sb, p, q, r;
    logic [W:0] x;
    int kk, kr;
    e.r = '0; e.rh = '0; e.c = 0; e.v = 0; e.z = 0; e.n = 0; e.lat = 1; e.e0 = 0;
    kk = int'(k);
    sa = s ? longint'($signed(a)) : longint'(a);
    sb = s ? longint'($signed(b)) : longint'(b);
    case (m)
      3'd0: begin
        p = sa * sb;
        {e.rh, e.r} = p[2*W-1:0];
        e.z = ({e.rh, e.r} == '0); e.n = e.rh[W-1]; e.c = e.r[W-1]; e.lat = W + 1;
      end
      3'd1: begin
        if (b == '0) begin
          e.r = '1; e.rh = a; e.v = 1; e.c = 1;
        end else begin
          e.lat = W + 1;
          if (s && a == 16'h8000 && b == 16'hFFFF) begin
            e.r = a; e.v = 1;
          end else begin
            q = sa / sb; r = sa % sb;
            e.r = q[W-1:0]; e.rh = r[W-1:0];
          end
        end
        e.z = (e.r == '0); e.n = e.r[W-1];
      end
      3'd7: begin
        e.r = a; e.c = ci;
      end
      default: begin
        e.lat = kk + 1;
        case (m)
          3'd2: begin
            e.r = (kk >= W) ? '0 : a << kk;
            e.c = (kk == 0) ? ci : (kk <= W) ? a[W-kk] : 1'b0;
            for (int i = 1; i <= kk; i++) begin
              logic bb;
              bb = (i <= W-1) ? a[W-1-i] : 1'b0;
              if (bb != a[W-1]) e.v = 1;
            end
          end
          3'd3: begin
            e.r = (kk >= W) ? '0 : a >> kk;
            e.c = (kk == 0) ? ci : (kk <= W) ? a[kk-1] : 1'b0;
          end
          3'd4: begin
            e.r = (kk >= W) ? {W{a[W-1]}} : W'($signed(a) >>> kk);
            e.c = (kk == 0) ? ci : (kk <= W) ? a[kk-1] : a[W-1];
          end
          default: begin
            x = {ci, a};
            kr = kk % (W + 1);
            if (kr != 0) begin
              if (m == 3'd5) x = (x << kr) | (x >> (W + 1 - kr));
              else           x = (x >> kr) | (x << (W + 1 - kr));
            end
            e.r = x[W-1:0]; e.c = x[W];
          end
        endcase
        e.z = (e.r == '0); e.n = e.r[W-1];
      end
    endcase
    return e;
  endfunction

  int last_done_e = -1;
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n && done && ecnt != last_done_e) begin
      last_done_e = ecnt;
      n_cmp++;
      if (sbq.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_done: got rslt=%h rslt_hi=%h, required no strobe", rslt, rslt_hi);
      end else begin
        e = sbq.pop_front();
        if ({busy, rslt_hi, rslt, c, v, z, n} !== {1'b0, e.rh, e.r, e.c, e.v, e.z, e.n}) begin
          n_bad++;
          $display("FAIL result: got busy=%b hi=%h lo=%h cvzn=%b%b%b%b, required busy=0 hi=%h lo=%h cvzn=%b%b%b%b",
                   busy, rslt_hi, rslt, c, v, z, n, e.rh, e.r, e.c, e.v, e.z, e.n);
        end
        n_cmp++;
        if (ecnt - e.e0 != e.lat) begin
          n_bad++;
          $display("FAIL latency: got %0d cen edges, required %0d", ecnt - e.e0, e.lat);
        end
      end
    end
  end

  task automatic issue(input logic [2:0] m, input logic s, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [CNTW-1:0] k, input logic ci);
    int g, k0;
    exp_t e;
    @(negedge clk);
    g = 0;
    while (busy && g < 3000) begin @(negedge clk); g++; end
    if (g >= 3000) begin
      n_cmp++; n_bad++;
      $display("FAIL busy_timeout: got busy=1 after %0d cycles, required idle", g);
    end
    mode = m; sign = s; opa = a; opb = b; cnt = k; cin = ci; start = 1'b1;
    k0 = ecnt; g = 0;
    do begin @(negedge clk); g++; end while (ecnt == k0 && g < 100);
    e = model(m, s, a, b, k, ci);
    e.e0 = ecnt;
    sbq.push_back(e);
    start = 1'b0;
    mode = 3'($urandom); sign = 1'($urandom); opa = W'($urandom); opb = W'($urandom);
    cnt = CNTW'($urandom); cin = 1'($urandom);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((sbq.size() != 0 || busy) && g < 5000) begin @(negedge clk); g++; end
    if (g >= 5000) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: got %0d results pending, required 0", sbq.size());
    end
  endtask

  task automatic chk_zero(input string nm);
    n_cmp++;
    if ({busy, done, rslt, rslt_hi, c, v, z, n} !== '0) begin
      n_bad++;
      $display("FAIL %s: got busy=%b done=%b lo=%h hi=%h cvzn=%b%b%b%b, required all zero",
               nm, busy, done, rslt, rslt_hi, c, v, z, n);
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [CNTW-1:0] rk;
    repeat (2) @(negedge clk);
    chk_zero("reset_state");
    rst_n = 1'b1;

    issue(3'd0, 1'b0, 16'h1234, 16'h0010, 8'd0, 1'b0);
    issue(3'd0, 1'b1, 16'hFFFD, 16'h0005, 8'd0, 1'b0);
    issue(3'd1, 1'b0, 16'h03E8, 16'h0007, 8'd0, 1'b0);
    issue(3'd1, 1'b1, 16'hFFF9, 16'h0002, 8'd0, 1'b0);
    issue(3'd1, 1'b0, 16'h5A5A, 16'h0000, 8'd0, 1'b0);
    issue(3'd1, 1'b1, 16'h8000, 16'hFFFF, 8'd0, 1'b0);
    issue(3'd2, 1'b0, 16'h4001, 16'h0000, 8'd2, 1'b0);
    issue(3'd6, 1'b0, 16'h1357, 16'h0000, 8'd0, 1'b1);
    issue(3'd4, 1'b0, 16'h8001, 16'h0000, 8'd3, 1'b0);
    issue(3'd7, 1'b1, 16'h00F0, 16'h1111, 8'd9, 1'b1);
    issue(3'd5, 1'b0, 16'h8001, 16'h0000, 8'd1, 1'b0);
    issue(3'd3, 1'b0, 16'h8001, 16'h0000, 8'd17, 1'b1);

    // Requests while busy must be dropped, not queued.
    issue(3'd0, 1'b1, 16'h8000, 16'h8000, 8'd0, 1'b0);
    repeat (3) begin
      if (busy) start = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    drain();

    cen_rand = 1'b1;
    for (int t = 0; t < 150; t++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: begin ra = 16'h8000; rb = 16'hFFFF; end
        2: ra = '0;
        default: ;
      endcase
      rk = ($urandom_range(0, 5) == 0) ? CNTW'($urandom) : CNTW'($urandom_range(0, 20));
      issue(3'($urandom), 1'($urandom), ra, rb, rk, 1'($urandom));
    end
    drain();
    cen_rand = 1'b0;

    issue(3'd0, 1'b0, 16'h1234, 16'h0010, 8'd0, 1'b0);
    drain();
    issue(3'd1, 1'b0, 16'h03E8, 16'h0007, 8'd0, 1'b0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("reset_abort");
    sbq.delete();
    repeat (2) @(negedge clk);
    chk_zero("reset_hold");
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    issue(3'd1, 1'b1, 16'hFFF9, 16'h0002, 8'd0, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
